alu381_sequencer: RTL and testbench

Command-side driver for the 4-bit 381-style ALU. Accepts operation requests over a valid/ready interface, sequences the ALU's operand and select lines so the ALU reliably re-evaluates, captures `{C,F}` after a fixed settle window, and returns a tagged response. The ALU only re-evaluates on a select change, so the sequencer always primes the select to 000 before applying the requested op.

---
 rtl/alu381_pkg.sv | 32 +++
 rtl/alu381_sequencer_if.sv | 39 +++
 rtl/alu381_sequencer.sv | 122 ++++++++++++
 tb/tb_alu381_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu381_pkg.sv
// rtl/alu381_pkg.sv - op codes, FSM states and helpers shared by the 381 ALU sequencer
package alu381_pkg;

  localparam logic [2:0] OP_CLR = 3'b000;
  localparam logic [2:0] OP_BMA = 3'b001;
  localparam logic [2:0] OP_AMB = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_APPLY,
    ST_DONE
  } state_t;

  // The ALU carry pin is meaningless for these, so the captured carry is zeroed
  function automatic logic is_logic_op(input logic [2:0] op);
    return (op == OP_XOR) || (op == OP_OR) || (op == OP_AND);
  endfunction

  // Clear and illegal are answered directly without driving the ALU
  function automatic logic skips_alu(input logic [2:0] op);
    return (op == OP_CLR) || (op == OP_ILL);
  endfunction

endpackage

// File: rtl/alu381_sequencer_if.sv
// rtl/alu381_sequencer_if.sv - command, ALU-pin and response bundle of the 381 ALU sequencer
interface alu381_sequencer_if #(
  parameter int TAG_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [2:0]       alu_s;
  logic [3:0]       alu_f;
  logic             alu_c;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_f;
  logic             rsp_c;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  logic             busy;

  // master is the environment: requester, response consumer and the ALU itself
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready, alu_f, alu_c,
    input  cmd_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_f, rsp_c, rsp_err, rsp_tag, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag, rsp_ready, alu_f, alu_c,
    output cmd_ready, alu_a, alu_b, alu_s, rsp_valid, rsp_f, rsp_c, rsp_err, rsp_tag, busy
  );

endinterface

// File: rtl/alu381_sequencer.sv
// rtl/alu381_sequencer.sv - primes the 381 select to 000, applies the op, captures {C,F} after SETTLE cycles
module alu381_sequencer
  import alu381_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int TAG_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu381_sequencer_if.slave  bus
);

  state_t                state;
  state_t                state_nxt;
  logic [SETTLE_W-1:0]   cnt;
  logic [2:0]            op_q;
  logic [3:0]            a_q;
  logic [3:0]            b_q;
  logic [3:0]            f_q;
  logic                  c_q;
  logic                  err_q;
  logic [TAG_W-1:0]      tag_q;

  logic                  cmd_ready_c;
  logic                  rsp_valid_c;
  logic                  busy_c;
  logic [2:0]            alu_s_c;
  logic                  accept;
  logic                  last_settle;

  assign accept      = bus.cmd_valid && cmd_ready_c;
  assign last_settle = (cnt == SETTLE_W'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    busy_c      = 1'b1;
    alu_s_c     = OP_CLR;
    case (state)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        busy_c      = 1'b0;
        if (bus.cmd_valid) begin
          state_nxt = skips_alu(bus.cmd_op) ? ST_DONE : ST_PRIME;
        end
      end
      ST_PRIME: begin
        state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        alu_s_c = op_q;
        if (last_settle) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      op_q  <= OP_CLR;
      a_q   <= '0;
      b_q   <= '0;
      f_q   <= '0;
      c_q   <= 1'b0;
      err_q <= 1'b0;
      tag_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.cmd_op;
        tag_q <= bus.cmd_tag;
        f_q   <= '0;
        c_q   <= 1'b0;
        err_q <= (bus.cmd_op == OP_ILL);
        cnt   <= '0;
        // Operand pins only move for ops that actually drive the ALU
        if (!skips_alu(bus.cmd_op)) begin
          a_q <= bus.cmd_a;
          b_q <= bus.cmd_b;
        end
      end
      if (state == ST_APPLY) begin
        cnt <= cnt + 1'b1;
        if (last_settle) begin
          f_q <= bus.alu_f;
          c_q <= is_logic_op(op_q) ? 1'b0 : bus.alu_c;
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.busy      = busy_c;
  assign bus.alu_s     = alu_s_c;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.rsp_f     = f_q;
  assign bus.rsp_c     = c_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_tag   = tag_q;

endmodule

// File: tb/tb_alu381_sequencer.sv
// tb/tb_alu381_sequencer.sv - directed bench for alu381_sequencer with a select-triggered 381 ALU model
module tb_alu381_sequencer;
  import alu381_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   lat;
  int   seen;
  logic [2:0] s_hist [0:63];

  always #5 clk = ~clk;

  alu381_sequencer_if #(.TAG_W(4)) bus ();

  alu381_sequencer #(.SETTLE(2), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 381 model: re-evaluates only when the select changes; logic ops leave carry high
  always @(bus.alu_s) begin
    logic [4:0] r;
    case (bus.alu_s)
      OP_CLR:  r = 5'h00;
      OP_BMA:  r = {1'b0, bus.alu_b} - {1'b0, bus.alu_a};
      OP_AMB:  r = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      OP_ADD:  r = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      OP_XOR:  r = {1'b1, bus.alu_a ^ bus.alu_b};
      OP_OR:   r = {1'b1, bus.alu_a | bus.alu_b};
      OP_AND:  r = {1'b1, bus.alu_a & bus.alu_b};
      default: r = 5'h0F;
    endcase
    bus.alu_c = r[4];
    bus.alu_f = r[3:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({p, "_busy"},      32'(bus.busy),      32'd0);
    chk({p, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({p, "_rsp_f"},     32'(bus.rsp_f),     32'd0);
    chk({p, "_rsp_c"},     32'(bus.rsp_c),     32'd0);
    chk({p, "_rsp_err"},   32'(bus.rsp_err),   32'd0);
    chk({p, "_rsp_tag"},   32'(bus.rsp_tag),   32'd0);
    chk({p, "_alu_a"},     32'(bus.alu_a),     32'd0);
    chk({p, "_alu_b"},     32'(bus.alu_b),     32'd0);
    chk({p, "_alu_s"},     32'(bus.alu_s),     32'd0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] tag);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_tag   = tag;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Returns the cycle (accept = cycle 0) in which rsp_valid is first seen, 0 on timeout
  task automatic wait_rsp(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      s_hist[i] = bus.alu_s;
      if (bus.rsp_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] tag, input int exp_lat,
                        input logic [3:0] exp_f, input logic exp_c, input logic exp_err);
    issue(op, a, b, tag);
    wait_rsp(lat);
    chk({name, "_latency"}, 32'(lat),         32'(exp_lat));
    chk({name, "_f"},       32'(bus.rsp_f),   32'(exp_f));
    chk({name, "_c"},       32'(bus.rsp_c),   32'(exp_c));
    chk({name, "_err"},     32'(bus.rsp_err), 32'(exp_err));
    chk({name, "_tag"},     32'(bus.rsp_tag), 32'(tag));
    chk({name, "_done_s"},  32'(bus.alu_s),   32'd0);
    consume();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_a     = 4'h0;
    bus.cmd_b     = 4'h0;
    bus.cmd_tag   = 4'h0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    reset_checks("reset");

    run_op("add", OP_ADD, 4'h9, 4'h8, 4'h5, 4, 4'h1, 1'b1, 1'b0);
    chk("add_s_c1", 32'(s_hist[1]), 32'd0);
    chk("add_s_c2", 32'(s_hist[2]), 32'd3);
    chk("add_s_c3", 32'(s_hist[3]), 32'd3);
    @(negedge clk);
    chk("add_after_ready", 32'(bus.cmd_ready), 32'd1);
    chk("add_after_valid", 32'(bus.rsp_valid), 32'd0);

    run_op("amb", OP_AMB, 4'h3, 4'h5, 4'h6, 4, 4'hE, 1'b1, 1'b0);
    run_op("bma", OP_BMA, 4'h3, 4'h5, 4'h7, 4, 4'h2, 1'b0, 1'b0);

    run_op("xor", OP_XOR, 4'hA, 4'h5, 4'h8, 4, 4'hF, 1'b0, 1'b0);
    chk("xor_s_c1", 32'(s_hist[1]), 32'd0);
    chk("xor_s_c2", 32'(s_hist[2]), 32'd4);
    chk("xor_s_c3", 32'(s_hist[3]), 32'd4);
    run_op("or",  OP_OR,  4'hA, 4'h5, 4'h9, 4, 4'hF, 1'b0, 1'b0);
    run_op("and", OP_AND, 4'hC, 4'hA, 4'hA, 4, 4'h8, 1'b0, 1'b0);

    run_op("clr", OP_CLR, 4'h7, 4'h7, 4'h1, 1, 4'h0, 1'b0, 1'b0);
    chk("clr_s_c1",   32'(s_hist[1]), 32'd0);
    chk("clr_a_hold", 32'(bus.alu_a), 32'hC);
    run_op("ill", OP_ILL, 4'h3, 4'h3, 4'h2, 1, 4'h0, 1'b0, 1'b1);
    chk("ill_s_c1",   32'(s_hist[1]), 32'd0);
    chk("ill_b_hold", 32'(bus.alu_b), 32'hA);

    // Backpressure with a second request waiting
    issue(OP_ADD, 4'h1, 4'h2, 4'h3);
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd4);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_ADD;
    bus.cmd_a     = 4'h4;
    bus.cmd_b     = 4'h4;
    bus.cmd_tag   = 4'h9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_f",     32'(bus.rsp_f),     32'd3);
      chk("bp_rsp_tag",   32'(bus.rsp_tag),   32'd3);
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      chk("bp_busy",      32'(bus.busy),      32'd1);
      chk("bp_alu_s",     32'(bus.alu_s),     32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    wait_rsp(lat);
    chk("bp2_latency", 32'(lat),         32'd4);
    chk("bp2_f",       32'(bus.rsp_f),   32'd8);
    chk("bp2_c",       32'(bus.rsp_c),   32'd0);
    chk("bp2_tag",     32'(bus.rsp_tag), 32'd9);
    consume();

    // Reset while the op select is applied
    issue(OP_ADD, 4'h6, 4'h7, 4'h2);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy",  32'(bus.busy),  32'd1);
    chk("rst_pre_alu_s", 32'(bus.alu_s), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    reset_checks("midrst");
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
